// File: rtl/ga20_pkg.sv
// ga20_pkg: widths, FSM state type and byte-lane helper shared by the GA20 sample cache.
// Revision 1.0
`default_nettype none

package ga20_pkg;
  localparam int GA20_ADDR_W     = 20;
  localparam int GA20_LINE_BYTES = 8;
  localparam int GA20_TAG_W      = 17;
  localparam int GA20_SDR_AW     = 25;
  localparam int GA20_LINE_W     = GA20_LINE_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2
  } ga20_state_e;

  function automatic logic [7:0] ga20_byte(input logic [GA20_LINE_W-1:0] d, input logic [2:0] sel);
    return d[8*sel +: 8];
  endfunction
endpackage

`default_nettype wire

// File: rtl/ga20_sample_cache_if.sv
// ga20_sample_cache_if: GA20 sample port plus SDRAM line-fill port of the sample cache.
// Revision 1.0
`default_nettype none

interface ga20_sample_cache_if;
  import ga20_pkg::*;

  logic                   rd;
  logic [GA20_ADDR_W-1:0] addr;
  logic                   flush;
  logic                   valid;
  logic [7:0]             dout;
  logic                   sdr_req;
  logic [GA20_SDR_AW-1:0] sdr_addr;
  logic                   sdr_ack;
  logic [GA20_LINE_W-1:0] sdr_data;

  modport slave  (input rd, addr, flush, sdr_ack, sdr_data,
                  output valid, dout, sdr_req, sdr_addr);
  modport master (output rd, addr, flush, sdr_ack, sdr_data,
                  input valid, dout, sdr_req, sdr_addr);
endinterface

`default_nettype wire

// File: rtl/ga20_tag_match.sv
// ga20_tag_match: single-cycle fully-associative tag compare, hit flag plus one-hot way.
// Revision 1.0
`default_nettype none

module ga20_tag_match
  import ga20_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic [GA20_TAG_W-1:0]            i_tag,
  input  logic [LINES-1:0][GA20_TAG_W-1:0] i_tags,
  input  logic [LINES-1:0]                 i_vld,
  output logic                             o_hit,
  output logic [LINES-1:0]                 o_onehot
);
  for (genvar g = 0; g < LINES; g++) begin : g_way
    assign o_onehot[g] = i_vld[g] && (i_tags[g] == i_tag);
  end

  assign o_hit = |o_onehot;
endmodule

`default_nettype wire

// File: rtl/ga20_sample_cache.sv
// ga20_sample_cache: small fully-associative line cache between the GA20 sample port and SDRAM.
// Revision 1.0
`default_nettype none

module ga20_sample_cache
  import ga20_pkg::*;
#(
  parameter int                     LINES    = 4,
  parameter logic [GA20_SDR_AW-1:0] ROM_BASE = 25'h0
) (
  input  logic               clk,
  input  logic               reset,
  ga20_sample_cache_if.slave bus
);
  localparam int VW = (LINES > 1) ? $clog2(LINES) : 1;

  ga20_state_e                     r_state, w_state_nx;
  logic [GA20_ADDR_W-1:0]          r_req_addr;
  logic [GA20_TAG_W-1:0]           r_fill_tag;
  logic                            r_valid;
  logic [7:0]                      r_dout;
  logic                            r_sdr_req;
  logic [GA20_SDR_AW-1:0]          r_sdr_addr;
  logic [LINES-1:0]                r_line_vld;
  logic [LINES-1:0][GA20_TAG_W-1:0] r_tag;
  logic [GA20_LINE_W-1:0]          r_data [LINES];
  logic [VW-1:0]                   r_victim;
  logic                            r_redo;
  logic                            r_drop;

  logic                   w_hit;
  logic [LINES-1:0]       w_onehot;
  logic [GA20_LINE_W-1:0] w_hit_data;
  logic                   w_hit_ret, w_start_fill, w_fill_done, w_fill_ret, w_install;

  ga20_tag_match #(.LINES(LINES)) u_match (
    .i_tag    (r_req_addr[GA20_ADDR_W-1:3]),
    .i_tags   (r_tag),
    .i_vld    (r_line_vld),
    .o_hit    (w_hit),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_hit_data = '0;
    for (int i = 0; i < LINES; i++)
      if (w_onehot[i]) w_hit_data = w_hit_data | r_data[i];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_hit_ret    = 1'b0;
    w_start_fill = 1'b0;
    w_fill_done  = 1'b0;
    w_fill_ret   = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_LOOKUP: begin
        if (w_hit) begin
          w_hit_ret  = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_start_fill = 1'b1;
          w_state_nx   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.sdr_ack) begin
          w_fill_done = 1'b1;
          if (r_redo) begin
            w_state_nx = ST_LOOKUP;
          end else begin
            w_fill_ret = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // A new read overrides any result; an in-flight fill must still see its ack first.
    if (bus.rd) begin
      w_hit_ret    = 1'b0;
      w_fill_ret   = 1'b0;
      w_start_fill = 1'b0;
      w_state_nx   = (r_state == ST_FILL && !bus.sdr_ack) ? ST_FILL : ST_LOOKUP;
    end
  end

  assign w_install = w_fill_done && !r_drop && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_addr <= '0;
      r_fill_tag <= '0;
      r_valid    <= 1'b0;
      r_dout     <= 8'h00;
      r_sdr_req  <= 1'b0;
      r_sdr_addr <= '0;
      r_line_vld <= '0;
      r_victim   <= '0;
      r_redo     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (bus.rd) begin
        r_req_addr <= bus.addr;
        r_valid    <= 1'b0;
      end
      if (w_hit_ret) begin
        r_valid <= 1'b1;
        r_dout  <= ga20_byte(w_hit_data, r_req_addr[2:0]);
      end
      if (w_fill_ret) begin
        r_valid <= 1'b1;
        r_dout  <= ga20_byte(bus.sdr_data, r_req_addr[2:0]);
      end
      if (w_start_fill) begin
        r_sdr_req  <= 1'b1;
        r_sdr_addr <= ROM_BASE + {5'b0, r_req_addr[GA20_ADDR_W-1:3], 3'b000};
        r_fill_tag <= r_req_addr[GA20_ADDR_W-1:3];
        r_redo     <= 1'b0;
        r_drop     <= 1'b0;
      end
      if (r_state == ST_FILL && bus.rd)    r_redo <= 1'b1;
      if (r_state == ST_FILL && bus.flush) r_drop <= 1'b1;
      if (w_fill_done) r_sdr_req <= 1'b0;
      if (w_install) begin
        r_line_vld[r_victim] <= 1'b1;
        r_victim <= (r_victim == VW'(LINES - 1)) ? '0 : r_victim + VW'(1);
      end
      if (bus.flush) begin
        r_line_vld <= '0;
        r_victim   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_install) begin
      r_data[r_victim] <= bus.sdr_data;
      r_tag[r_victim]  <= r_fill_tag;
    end
  end

  assign bus.valid    = r_valid;
  assign bus.dout     = r_dout;
  assign bus.sdr_req  = r_sdr_req;
  assign bus.sdr_addr = r_sdr_addr;
endmodule

`default_nettype wire

// File: doc/ga20_sample_cache.md
GA20_SAMPLE_CACHE -- requirements
Module: ga20_sample_cache

Interface
REQ-001 Parameter LINES, default 4, number of fully-associative 8-byte cache lines (power of two, 2..8).
REQ-002 Parameter ROM_BASE, default 25'h0, SDRAM byte address of GA20 sample ROM byte 0.
REQ-003 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 rd  in  1  single-cycle read strobe from GA20 (sample_rd).
REQ-006 addr  in  20  sample byte address, valid while rd=1.
REQ-007 flush  in  1  single-cycle pulse; invalidates all lines (ROM reload).
REQ-008 valid  out  1  dout holds the byte for the last rd address (sample_valid).
REQ-009 dout  out  8  sample byte (sample_din).
REQ-010 sdr_req  out  1  SDRAM burst request, level, held until sdr_ack.
REQ-011 sdr_addr  out  25  SDRAM byte address of the line, 8-byte aligned, stable while sdr_req=1.
REQ-012 sdr_ack  in  1  single-cycle pulse; sdr_data valid in the same cycle.
REQ-013 sdr_data  in  64  line data, byte n = bits [8n+7:8n].

Function
REQ-014 States: IDLE, LOOKUP, FILL; single outstanding SDRAM request maximum.
REQ-015 rd in any state: latch addr into req_addr, drive valid=0 in the next cycle, go to LOOKUP.
REQ-016 LOOKUP: compare req_addr[19:3] against all valid tags in one cycle.
REQ-017 Hit: dout=line byte req_addr[2:0], valid=1 the next cycle, go to IDLE; rd at cycle T gives valid=1 at T+2.
REQ-018 Miss: go to FILL; sdr_req=1 and sdr_addr=ROM_BASE+{req_addr[19:3],3'b000} from the next cycle.
REQ-019 FILL with sdr_ack: write sdr_data and tag into the victim line, set its valid bit, advance the victim pointer (LINES-1 wraps to 0), and drop sdr_req the next cycle.
REQ-020 FILL completion when req_addr is unchanged: dout=selected byte from sdr_data and valid=1 at ack+1, go to IDLE.
REQ-021 rd during FILL: keep sdr_req and sdr_addr unchanged until ack, install the line, then go to LOOKUP for the new req_addr; valid stays 0 throughout.
REQ-022 rd and sdr_ack in the same cycle: install the line; the new address takes priority and goes to LOOKUP.
REQ-023 Victim pointer: round-robin only; a hit does not change it; duplicate tags cannot occur.
REQ-024 IDLE: valid and dout hold their values until the next rd.
REQ-025 flush: clear all line valid bits next cycle; victim pointer reset to 0.
REQ-026 flush during FILL: the pending ack data is not installed but is still returned if req_addr is unchanged.
REQ-027 flush together with sdr_ack: the flush wins and the line is not installed.
REQ-028 sdr_addr arithmetic: 25-bit modulo add, no overflow flag.

Reset
REQ-029 Reset state: state=IDLE, valid=0, dout=8'h00, sdr_req=0, sdr_addr=0, all line valid bits=0, victim pointer=0.
REQ-030 Reset during FILL: abandon the request; drop sdr_req the next cycle; ignore any later sdr_ack until a new request is issued.
REQ-031 Line data and tag storage are not reset.

Structure
REQ-032 Shared package ga20_pkg shall hold: GA20_ADDR_W=20, GA20_LINE_BYTES=8, GA20_TAG_W=17, and the state enum type.
REQ-033 One sub-module, ga20_tag_match, shall provide the combinational LINES-way tag compare returning hit and a one-hot index; everything else stays in the top.

Verification
REQ-034 Cold miss: rd addr=20'h01234 -> sdr_req=1, sdr_addr=25'h0001230; ack with sdr_data=64'h8877665544332211 -> valid=1, dout=8'h55 at ack+1.
REQ-035 Hit: after REQ-034, rd addr=20'h01237 -> no sdr_req; valid=1, dout=8'h88 exactly 2 cycles after rd.
REQ-036 Replacement: with LINES=4, fill lines 0x000, 0x008, 0x010, 0x018, 0x020, then rd 0x000 -> a miss refetches 25'h0000000 (line 0 evicted).
REQ-037 rd during FILL: rd 0x100, then rd 0x200 two cycles later -> one sdr_req at 0x100, then a second at 0x200; valid=0 until the 0x200 data returns.
REQ-038 Flush: fill 0x040, pulse flush, rd 0x041 -> a new sdr_req at 0x040; and flush coinciding with ack -> the line is not cached.
REQ-039 Reset mid-FILL: assert reset while sdr_req=1 -> sdr_req=0 and valid=0 the next cycle; a stale sdr_ack pulse changes no state.
